// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// load_store_unit
//
// Memory-stage sequencer that sits in front of a 16-bit word-addressed data
// memory with synchronous read and write. It takes one load/store request at a
// time and drives the memory address, data and enable pins. It absorbs the
// memory's one-cycle registered read latency and performs byte loads with
// sign or zero extension. Byte stores are done as read-modify-write. Each
// request ends with a single-cycle response to write-back.
//
// Ports
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   req_valid/ready : request handshake, accepted on req_valid & req_ready
//   req_op          : 000 LW, 001 LB, 010 LBU, 011 SW, 100 SB, others illegal
//   req_addr        : byte address
//   req_wdata       : store data (SB uses [7:0])
//   req_rd          : destination tag echoed on the response
//   resp_valid      : one-cycle completion pulse
//   resp_data       : load result, 0 for stores and faults
//   resp_rd         : tag of the completed request
//   resp_fault      : request rejected, memory untouched
//   stall           : req_valid while the unit is busy
//   mem_addr        : word address to memory (byte address >> 1)
//   mem_datain      : write data to memory
//   mem_read        : memory MemRead
//   mem_write       : memory MemWrite
//   mem_dataout     : read data from memory, valid one cycle after a read edge
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic [2:0]  req_rd,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic [2:0]  resp_rd,
    output logic        resp_fault,
    output logic        stall,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_datain,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [15:0] mem_dataout
);

    typedef enum logic [1:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        FINISH
    } state_t;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_SW  = 3'b011;
    localparam logic [2:0] OP_SB  = 3'b100;

    localparam logic [16:0] ADDR_LIMIT = 17'(2 * DEPTH);

    state_t      state, state_next;

    // Request fields captured at acceptance so the requester may change
    // req_* freely while the operation is in flight.
    logic [2:0]  op_q, op_next;
    logic        byte_sel_q, byte_sel_next;
    logic [7:0]  wbyte_q, wbyte_next;
    logic [2:0]  rd_q, rd_next;
    logic        fault_q, fault_next;

    logic        mem_read_next, mem_write_next;
    logic [15:0] mem_addr_next, mem_datain_next;
    logic        resp_valid_next, resp_fault_next;
    logic [15:0] resp_data_next;
    logic [2:0]  resp_rd_next;

    logic        accept_fault;
    logic [7:0]  sel_byte;
    logic [15:0] load_result;
    logic [15:0] merged_word;

    assign req_ready = (state == IDLE);
    assign stall     = req_valid & ~req_ready;

    // A request is rejected up front for an illegal opcode, an address past
    // the end of memory, or a word access on an odd byte address.
    always_comb begin
        accept_fault = 1'b0;
        if (req_op > OP_SB) begin
            accept_fault = 1'b1;
        end
        if ({1'b0, req_addr} >= ADDR_LIMIT) begin
            accept_fault = 1'b1;
        end
        if ((req_op == OP_LW || req_op == OP_SW) && req_addr[0]) begin
            accept_fault = 1'b1;
        end
    end

    // Byte lane selection on the returned word (little-endian), extension for
    // byte loads, and the merged word for the write half of a byte store.
    always_comb begin
        sel_byte    = byte_sel_q ? mem_dataout[15:8] : mem_dataout[7:0];
        load_result = {8'h00, sel_byte};
        if (op_q == OP_LW) begin
            load_result = mem_dataout;
        end else if (op_q == OP_LB) begin
            load_result = {{8{sel_byte[7]}}, sel_byte};
        end
        merged_word = byte_sel_q ? {wbyte_q, mem_dataout[7:0]}
                                 : {mem_dataout[15:8], wbyte_q};
    end

    // Next-state and next-output logic. Memory enables and the response pulse
    // default low so each is asserted for exactly one cycle; address, write
    // data and response payload hold unless explicitly updated.
    always_comb begin
        state_next      = state;
        op_next         = op_q;
        byte_sel_next   = byte_sel_q;
        wbyte_next      = wbyte_q;
        rd_next         = rd_q;
        fault_next      = fault_q;
        mem_read_next   = 1'b0;
        mem_write_next  = 1'b0;
        mem_addr_next   = mem_addr;
        mem_datain_next = mem_datain;
        resp_valid_next = 1'b0;
        resp_data_next  = resp_data;
        resp_rd_next    = resp_rd;
        resp_fault_next = resp_fault;

        case (state)
            IDLE: begin
                if (req_valid) begin
                    op_next       = req_op;
                    byte_sel_next = req_addr[0];
                    wbyte_next    = req_wdata[7:0];
                    rd_next       = req_rd;
                    fault_next    = accept_fault;
                    mem_addr_next = {1'b0, req_addr[15:1]};
                    if (accept_fault) begin
                        state_next = FINISH;
                    end else if (req_op == OP_SW) begin
                        state_next      = FINISH;
                        mem_write_next  = 1'b1;
                        mem_datain_next = req_wdata;
                    end else begin
                        state_next    = RD_ISSUE;
                        mem_read_next = 1'b1;
                    end
                end
            end
            RD_ISSUE: begin
                state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (op_q == OP_SB) begin
                    state_next      = FINISH;
                    mem_write_next  = 1'b1;
                    mem_datain_next = merged_word;
                end else begin
                    state_next      = IDLE;
                    resp_valid_next = 1'b1;
                    resp_data_next  = load_result;
                    resp_rd_next    = rd_q;
                    resp_fault_next = 1'b0;
                end
            end
            FINISH: begin
                state_next      = IDLE;
                resp_valid_next = 1'b1;
                resp_data_next  = 16'h0000;
                resp_rd_next    = rd_q;
                resp_fault_next = fault_q;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs. Reset drops any in-flight request and
    // clears the memory enables at once, so a pending write never lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_q       <= 3'b000;
            byte_sel_q <= 1'b0;
            wbyte_q    <= 8'h00;
            rd_q       <= 3'b000;
            fault_q    <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= 16'h0000;
            mem_datain <= 16'h0000;
            resp_valid <= 1'b0;
            resp_data  <= 16'h0000;
            resp_rd    <= 3'b000;
            resp_fault <= 1'b0;
        end else begin
            state      <= state_next;
            op_q       <= op_next;
            byte_sel_q <= byte_sel_next;
            wbyte_q    <= wbyte_next;
            rd_q       <= rd_next;
            fault_q    <= fault_next;
            mem_read   <= mem_read_next;
            mem_write  <= mem_write_next;
            mem_addr   <= mem_addr_next;
            mem_datain <= mem_datain_next;
            resp_valid <= resp_valid_next;
            resp_data  <= resp_data_next;
            resp_rd    <= resp_rd_next;
            resp_fault <= resp_fault_next;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Directed bench for load_store_unit. A small synchronous 32-word memory model
// sits behind the unit; expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LB  = 3'b001;
    localparam logic [2:0] OP_LBU = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b011;
    localparam logic [2:0] OP_SB  = 3'b100;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [2:0]  req_rd;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic [2:0]  resp_rd;
    logic        resp_fault;
    logic        stall;
    logic [15:0] mem_addr;
    logic [15:0] mem_datain;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_dataout;

    logic [15:0] mem [0:31];
    logic        memClear;
    logic        pokeEn;
    logic [4:0]  pokeAddr;
    logic [15:0] pokeData;

    int checkCount;
    int errorCount;
    int overlapCount;
    int respCount;
    int lat;
    int respBefore;

    load_store_unit #(.DEPTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_fault (resp_fault),
        .stall      (stall),
        .mem_addr   (mem_addr),
        .mem_datain (mem_datain),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_dataout(mem_dataout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous data memory: registered read, write on the same edge.
    always @(posedge clk) begin
        if (memClear) begin
            for (int i = 0; i < 32; i++) mem[i] <= 16'h0000;
        end else begin
            if (mem_read === 1'b1) mem_dataout <= mem[mem_addr[4:0]];
            if (mem_write === 1'b1) mem[mem_addr[4:0]] <= mem_datain;
            if (pokeEn) mem[pokeAddr] <= pokeData;
        end
    end

    // Running monitors for enable overlap and response pulses.
    always @(posedge clk) begin
        if (mem_read === 1'b1 && mem_write === 1'b1) overlapCount++;
        if (resp_valid === 1'b1) respCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pokeWord(input logic [4:0] a, input logic [15:0] d);
        pokeEn   = 1'b1;
        pokeAddr = a;
        pokeData = d;
        tick();
        pokeEn   = 1'b0;
    endtask

    // Present a request, wait (bounded) for ready, return just after the
    // acceptance edge with req_valid dropped.
    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [2:0] rd);
        bit gotReady;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        req_valid = 1'b1;
        gotReady  = req_ready;
        for (int i = 0; i < 8 && !gotReady; i++) begin
            tick();
            gotReady = req_ready;
        end
        if (!gotReady) checkOutput("ready_timeout", 32'd0, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Count edges until resp_valid is seen; lat = -1 if it never arrives.
    task automatic waitResponse(input int start, output int latency);
        int cnt;
        bit seen;
        cnt     = start;
        seen    = 1'b0;
        latency = -1;
        for (int i = 0; i < 8 && !seen; i++) begin
            tick();
            cnt++;
            if (resp_valid === 1'b1) begin
                seen    = 1'b1;
                latency = cnt;
            end
        end
    endtask

    initial begin
        checkCount   = 0;
        errorCount   = 0;
        overlapCount = 0;
        respCount    = 0;
        rst          = 1'b1;
        memClear     = 1'b1;
        pokeEn       = 1'b0;
        pokeAddr     = 5'd0;
        pokeData     = 16'h0000;
        req_valid    = 1'b0;
        req_op       = 3'b000;
        req_addr     = 16'h0000;
        req_wdata    = 16'h0000;
        req_rd       = 3'b000;

        // Reset state
        #2;
        checkOutput("rst_mem_read", 32'(mem_read), 32'd0);
        checkOutput("rst_mem_write", 32'(mem_write), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_datain", 32'(mem_datain), 32'd0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_data", 32'(resp_data), 32'd0);
        checkOutput("rst_resp_rd", 32'(resp_rd), 32'd0);
        checkOutput("rst_resp_fault", 32'(resp_fault), 32'd0);
        tick();
        memClear = 1'b0;
        rst      = 1'b0;
        #1;
        checkOutput("rst_ready", 32'(req_ready), 32'd1);

        // Byte loads from word 5 = 0x80F3
        pokeWord(5'd5, 16'h80F3);
        applyStimulus(OP_LB, 16'h000A, 16'h0000, 3'd3);
        checkOutput("lb_mem_addr", 32'(mem_addr), 32'd5);
        checkOutput("lb_mem_read", 32'(mem_read), 32'd1);
        waitResponse(0, lat);
        checkOutput("lb_latency", 32'(lat), 32'd2);
        checkOutput("lb_data", 32'(resp_data), 32'h0000FFF3);
        checkOutput("lb_rd", 32'(resp_rd), 32'd3);
        checkOutput("lb_fault", 32'(resp_fault), 32'd0);
        applyStimulus(OP_LBU, 16'h000B, 16'h0000, 3'd5);
        waitResponse(0, lat);
        checkOutput("lbu_latency", 32'(lat), 32'd2);
        checkOutput("lbu_data", 32'(resp_data), 32'h00000080);
        checkOutput("lbu_rd", 32'(resp_rd), 32'd5);

        // SW then back-to-back LW to word 8
        applyStimulus(OP_SW, 16'h0010, 16'h1234, 3'd1);
        checkOutput("sw_mem_write", 32'(mem_write), 32'd1);
        checkOutput("sw_mem_datain", 32'(mem_datain), 32'h1234);
        checkOutput("sw_mem_before", 32'(mem[8]), 32'h0000);
        waitResponse(0, lat);
        checkOutput("sw_latency", 32'(lat), 32'd1);
        checkOutput("sw_mem_after", 32'(mem[8]), 32'h1234);
        checkOutput("sw_data", 32'(resp_data), 32'd0);
        checkOutput("sw_rd", 32'(resp_rd), 32'd1);
        checkOutput("sw_ready", 32'(req_ready), 32'd1);
        applyStimulus(OP_LW, 16'h0010, 16'h0000, 3'd2);
        checkOutput("lw_write_cleared", 32'(mem_write), 32'd0);
        req_valid = 1'b1;
        checkOutput("lw_stall_issue", 32'(stall), 32'd1);
        tick();
        checkOutput("lw_stall_wait", 32'(stall), 32'd1);
        req_valid = 1'b0;
        waitResponse(1, lat);
        checkOutput("lw_latency", 32'(lat), 32'd2);
        checkOutput("lw_data", 32'(resp_data), 32'h1234);
        checkOutput("lw_rd", 32'(resp_rd), 32'd2);

        // Faults: misaligned LW, out-of-range SW, illegal op
        applyStimulus(OP_LW, 16'h0003, 16'h0000, 3'd6);
        checkOutput("flw_enables", 32'({mem_read, mem_write}), 32'd0);
        waitResponse(0, lat);
        checkOutput("flw_latency", 32'(lat), 32'd1);
        checkOutput("flw_fault", 32'(resp_fault), 32'd1);
        checkOutput("flw_data", 32'(resp_data), 32'd0);
        checkOutput("flw_rd", 32'(resp_rd), 32'd6);
        applyStimulus(OP_SW, 16'h0040, 16'hDEAD, 3'd7);
        checkOutput("fsw_enables", 32'({mem_read, mem_write}), 32'd0);
        waitResponse(0, lat);
        checkOutput("fsw_latency", 32'(lat), 32'd1);
        checkOutput("fsw_fault", 32'(resp_fault), 32'd1);
        checkOutput("fsw_data", 32'(resp_data), 32'd0);
        checkOutput("fsw_mem0", 32'(mem[0]), 32'h0000);
        applyStimulus(3'b111, 16'h0004, 16'h0000, 3'd4);
        checkOutput("fop_enables", 32'({mem_read, mem_write}), 32'd0);
        waitResponse(0, lat);
        checkOutput("fop_latency", 32'(lat), 32'd1);
        checkOutput("fop_fault", 32'(resp_fault), 32'd1);
        checkOutput("fop_data", 32'(resp_data), 32'd0);

        // Byte stores into word 3 = 0xAABB
        pokeWord(5'd3, 16'hAABB);
        applyStimulus(OP_SB, 16'h0007, 16'hFF5C, 3'd4);
        waitResponse(0, lat);
        checkOutput("sb_hi_latency", 32'(lat), 32'd3);
        checkOutput("sb_hi_mem", 32'(mem[3]), 32'h5CBB);
        checkOutput("sb_hi_fault", 32'(resp_fault), 32'd0);
        checkOutput("sb_hi_rd", 32'(resp_rd), 32'd4);
        applyStimulus(OP_SB, 16'h0006, 16'h0011, 3'd5);
        waitResponse(0, lat);
        checkOutput("sb_lo_latency", 32'(lat), 32'd3);
        checkOutput("sb_lo_mem", 32'(mem[3]), 32'h5C11);
        checkOutput("sb_lo_data", 32'(resp_data), 32'd0);

        // Reset during RD_WAIT of an SB
        applyStimulus(OP_LW, 16'h0006, 16'h0000, 3'd7);
        waitResponse(0, lat);
        checkOutput("pre_rst_lw_data", 32'(resp_data), 32'h5C11);
        applyStimulus(OP_SB, 16'h0006, 16'h0077, 3'd6);
        tick();
        #2;
        rst = 1'b1;
        #1;
        respBefore = respCount;
        checkOutput("arst_mem_read", 32'(mem_read), 32'd0);
        checkOutput("arst_mem_write", 32'(mem_write), 32'd0);
        checkOutput("arst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("arst_mem_datain", 32'(mem_datain), 32'd0);
        checkOutput("arst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("arst_resp_data", 32'(resp_data), 32'd0);
        checkOutput("arst_resp_rd", 32'(resp_rd), 32'd0);
        checkOutput("arst_resp_fault", 32'(resp_fault), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (4) tick();
        checkOutput("arst_no_resp", 32'(respCount - respBefore), 32'd0);
        checkOutput("arst_mem_unchanged", 32'(mem[3]), 32'h5C11);
        checkOutput("arst_ready", 32'(req_ready), 32'd1);

        // Request fields change while busy; held request taken on resp cycle
        applyStimulus(OP_LW, 16'h0010, 16'h0000, 3'd2);
        req_valid = 1'b1;
        req_op    = OP_SB;
        req_addr  = 16'h0003;
        req_wdata = 16'h0000;
        req_rd    = 3'd7;
        checkOutput("hold_stall", 32'(stall), 32'd1);
        tick();
        req_op    = OP_SW;
        req_addr  = 16'h0014;
        req_wdata = 16'hBEEF;
        req_rd    = 3'd1;
        tick();
        checkOutput("hold_resp_valid", 32'(resp_valid), 32'd1);
        checkOutput("hold_lw_data", 32'(resp_data), 32'h1234);
        checkOutput("hold_lw_rd", 32'(resp_rd), 32'd2);
        checkOutput("hold_ready", 32'(req_ready), 32'd1);
        checkOutput("hold_no_stall", 32'(stall), 32'd0);
        tick();
        req_valid = 1'b0;
        checkOutput("hold_sw_write", 32'(mem_write), 32'd1);
        checkOutput("hold_sw_addr", 32'(mem_addr), 32'd10);
        waitResponse(0, lat);
        checkOutput("hold_sw_latency", 32'(lat), 32'd1);
        checkOutput("hold_sw_mem", 32'(mem[10]), 32'hBEEF);
        checkOutput("hold_sw_rd", 32'(resp_rd), 32'd1);

        checkOutput("no_enable_overlap", 32'(overlapCount), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
